// File: rtl/lab3_cache_line_xfer.sv
// Line transfer engine: turns one refill/spill line command into WORDS in-order
// single-word memory requests and returns the assembled line or a spill ack.
`timescale 1ns/1ps
module lab3_cache_line_xfer #(
   parameter int unsigned WORDS  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      cmd_val,
   output logic                      cmd_rdy,
   input  logic                      cmd_type,
   input  logic [ADDR_W-1:0]         cmd_addr,
   input  logic [WORDS*DATA_W-1:0]   cmd_data,
   output logic                      memreq_val,
   input  logic                      memreq_rdy,
   output logic                      memreq_type,
   output logic [ADDR_W-1:0]         memreq_addr,
   output logic [DATA_W-1:0]         memreq_data,
   input  logic                      memresp_val,
   output logic                      memresp_rdy,
   input  logic                      memresp_type,
   input  logic [DATA_W-1:0]         memresp_data,
   output logic                      done_val,
   input  logic                      done_rdy,
   output logic                      done_type,
   output logic [WORDS*DATA_W-1:0]   done_data
);

   localparam int unsigned LINE_W = WORDS * DATA_W;
   localparam int unsigned OFF    = $clog2(LINE_W / 8);
   localparam int unsigned IDX_W  = $clog2(WORDS);
   localparam int unsigned CNT_W  = IDX_W + 1;
   localparam int unsigned BYTES  = DATA_W / 8;
   localparam logic [ADDR_W-1:0] BASE_MASK = {ADDR_W{1'b1}} << OFF;

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

   state_e              state_q, state_d;
   logic                type_q, type_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [LINE_W-1:0]   line_q, line_d;
   logic [LINE_W-1:0]   buf_q, buf_d;
   logic [CNT_W-1:0]    req_cnt_q, req_cnt_d;
   logic [CNT_W-1:0]    resp_cnt_q, resp_cnt_d;
   logic [IDX_W-1:0]    req_idx, resp_idx;
   logic                req_ok, resp_ok;

   assign req_idx  = req_cnt_q[IDX_W-1:0];
   assign resp_idx = resp_cnt_q[IDX_W-1:0];
   assign req_ok   = (state_q == XFER) && (req_cnt_q < CNT_W'(WORDS));
   assign resp_ok  = (state_q == XFER) && (resp_cnt_q < req_cnt_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         type_q     <= 1'b0;
         base_q     <= '0;
         line_q     <= '0;
         buf_q      <= '0;
         req_cnt_q  <= '0;
         resp_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         base_q     <= base_d;
         line_q     <= line_d;
         buf_q      <= buf_d;
         req_cnt_q  <= req_cnt_d;
         resp_cnt_q <= resp_cnt_d;
      end
   end

   // Next-state and handshake outputs; memreq_* depend only on registered state.
   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      base_d      = base_q;
      line_d      = line_q;
      buf_d       = buf_q;
      req_cnt_d   = req_cnt_q;
      resp_cnt_d  = resp_cnt_q;
      cmd_rdy     = 1'b0;
      memreq_val  = 1'b0;
      memreq_type = 1'b0;
      memreq_addr = base_q + ADDR_W'(req_cnt_q) * ADDR_W'(BYTES);
      memreq_data = '0;
      memresp_rdy = 1'b0;
      done_val    = 1'b0;
      done_type   = 1'b0;
      done_data   = '0;
      case (state_q)
         IDLE: begin
            cmd_rdy = 1'b1;
            if (cmd_val) begin
               type_d     = cmd_type;
               base_d     = cmd_addr & BASE_MASK;
               line_d     = cmd_data;
               buf_d      = '0;
               req_cnt_d  = '0;
               resp_cnt_d = '0;
               state_d    = XFER;
            end
         end
         XFER: begin
            memreq_val  = req_ok;
            memreq_type = type_q;
            memreq_data = type_q ? line_q[req_idx*DATA_W +: DATA_W] : '0;
            memresp_rdy = resp_ok;
            if (req_ok && memreq_rdy) begin
               req_cnt_d = req_cnt_q + CNT_W'(1);
            end
            if (resp_ok && memresp_val) begin
               if (!type_q) begin
                  buf_d[resp_idx*DATA_W +: DATA_W] = memresp_data;
               end
               resp_cnt_d = resp_cnt_q + CNT_W'(1);
               if (resp_cnt_q == CNT_W'(WORDS - 1)) begin
                  state_d = DONE;
               end
            end
         end
         DONE: begin
            done_val  = 1'b1;
            done_type = type_q;
            done_data = type_q ? '0 : buf_q;
            if (done_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory must answer with the same operation type it was asked for.
   resp_type_match_a: assert property (@(posedge clk) disable iff (reset)
      (memresp_val && memresp_rdy) |-> (memresp_type == type_q));

endmodule

// File: tb/tb_lab3_cache_line_xfer.sv
// Randomized scoreboard bench for lab3_cache_line_xfer with a word-addressed
// memory model and a line-level reference model.
`timescale 1ns/1ps
module tb_lab3_cache_line_xfer;

   localparam int unsigned WORDS  = 4;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned LW     = WORDS * DATA_W;

   typedef struct { logic t; logic [31:0] a; logic [31:0] d; } req_t;
   typedef struct { logic t; logic [LW-1:0] d; } done_t;
   typedef struct { int rdy; logic t; logic [31:0] d; } resp_t;

   logic clk = 1'b0;
   logic reset;
   logic cmd_val, cmd_rdy, cmd_type;
   logic [ADDR_W-1:0] cmd_addr;
   logic [LW-1:0] cmd_data;
   logic memreq_val, memreq_rdy, memreq_type;
   logic [ADDR_W-1:0] memreq_addr;
   logic [DATA_W-1:0] memreq_data;
   logic memresp_val, memresp_rdy, memresp_type;
   logic [DATA_W-1:0] memresp_data;
   logic done_val, done_rdy, done_type;
   logic [LW-1:0] done_data;

   req_t  exp_req[$];
   done_t exp_done[$];
   resp_t pq[$];
   logic [31:0] bfm_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   int checks = 0, errors = 0, cyc = 0;
   int rdy_pct = 100, resp_pct = 100, done_pct = 100, dly_min = 1, dly_max = 1;
   bit alt_rdy = 0, alt_ph = 0;
   int done_stall = 0, stale_cnt = 0, n_req = 0, n_resp = 0;
   int done_fire_cyc = 0, done_first_cyc = 0, cmd_fire_cyc = 0;

   lab3_cache_line_xfer #(.WORDS(WORDS), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset),
      .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_type(cmd_type),
      .cmd_addr(cmd_addr), .cmd_data(cmd_data),
      .memreq_val(memreq_val), .memreq_rdy(memreq_rdy), .memreq_type(memreq_type),
      .memreq_addr(memreq_addr), .memreq_data(memreq_data),
      .memresp_val(memresp_val), .memresp_rdy(memresp_rdy),
      .memresp_type(memresp_type), .memresp_data(memresp_data),
      .done_val(done_val), .done_rdy(done_rdy), .done_type(done_type),
      .done_data(done_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
   endtask

   function automatic logic [31:0] ref_rd(input logic [31:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : a;
   endfunction

   // Reference model: a line command is WORDS word accesses at base + 4*i.
   task automatic issue(input logic t, input logic [31:0] a, input logic [LW-1:0] d);
      logic [31:0] base, wa;
      logic [LW-1:0] line;
      req_t r;
      done_t e;
      int tmo;
      base = a & ~32'(WORDS * DATA_W / 8 - 1);
      line = '0;
      for (int i = 0; i < int'(WORDS); i++) begin
         wa = base + 32'(4 * i);
         r.t = t; r.a = wa; r.d = t ? d[i*DATA_W +: DATA_W] : 32'h0;
         exp_req.push_back(r);
         if (t) ref_mem[wa] = d[i*DATA_W +: DATA_W];
         else   line[i*DATA_W +: DATA_W] = ref_rd(wa);
      end
      e.t = t; e.d = t ? '0 : line;
      exp_done.push_back(e);
      cmd_val = 1'b1; cmd_type = t; cmd_addr = a; cmd_data = d;
      tmo = 0;
      while (1) begin
         @(negedge clk);
         if (cmd_rdy) break;
         tmo++;
         if (tmo > 400) begin fail_now("cmd_accept_timeout"); break; end
      end
      cmd_fire_cyc = cyc;
      @(posedge clk); #1;
      cmd_val = 1'b0; cmd_type = 1'($urandom); cmd_addr = $urandom;
      cmd_data = {$urandom, $urandom, $urandom, $urandom};
   endtask

   task automatic wait_done();
      int tmo = 0;
      while (exp_done.size() != 0 && tmo < 600) begin
         @(posedge clk); #1; tmo++;
      end
      if (exp_done.size() != 0) fail_now("done_timeout");
   endtask

   // Memory BFM plus monitor: all DUT outputs sampled at the falling edge.
   bit prev_stall = 0, prev_dstall = 0, prev_dv = 0;
   logic [31:0] prev_addr, prev_data;
   logic [LW-1:0] prev_dd;
   always @(negedge clk) begin
      req_t r;
      resp_t p;
      done_t e;
      if (reset) begin
         pq.delete();
         n_req = 0; n_resp = 0;
         prev_stall = 0; prev_dstall = 0; prev_dv = 0;
         memreq_rdy = 0; memresp_val = 0; done_rdy = 0;
      end else begin
         check("resp_rdy_iff_outstanding", LW'(memresp_rdy), LW'(n_req > n_resp));
         if (prev_stall) begin
            check("req_hold_val", LW'(memreq_val), LW'(1'b1));
            check("req_hold_addr", LW'(memreq_addr), LW'(prev_addr));
            check("req_hold_data", LW'(memreq_data), LW'(prev_data));
         end
         memreq_rdy = alt_rdy ? alt_ph : ($urandom_range(99) < rdy_pct);
         alt_ph = ~alt_ph;
         if (memreq_val && memreq_rdy) begin
            if (exp_req.size() == 0) fail_now("unexpected_req");
            else begin
               r = exp_req.pop_front();
               check("req_type", LW'(memreq_type), LW'(r.t));
               check("req_addr", LW'(memreq_addr), LW'(r.a));
               check("req_data", LW'(memreq_data), LW'(r.d));
            end
            p.t = memreq_type;
            p.rdy = cyc + $urandom_range(dly_max, dly_min);
            if (memreq_type) begin
               bfm_mem[memreq_addr] = memreq_data;
               p.d = $urandom;
            end else begin
               p.d = bfm_mem.exists(memreq_addr) ? bfm_mem[memreq_addr] : memreq_addr;
            end
            pq.push_back(p);
            n_req++;
         end
         prev_stall = memreq_val && !memreq_rdy;
         prev_addr = memreq_addr; prev_data = memreq_data;

         if (stale_cnt > 0) begin
            memresp_val = 1; memresp_type = 1'($urandom); memresp_data = $urandom;
            check("stale_resp_rdy", LW'(memresp_rdy), LW'(1'b0));
            stale_cnt--;
         end else if (pq.size() > 0 && pq[0].rdy <= cyc && $urandom_range(99) < resp_pct) begin
            memresp_val = 1; memresp_type = pq[0].t; memresp_data = pq[0].d;
            if (memresp_rdy) begin
               void'(pq.pop_front());
               n_resp++;
            end
         end else begin
            memresp_val = 0; memresp_type = 1'($urandom); memresp_data = $urandom;
         end

         if (prev_dstall) begin
            check("done_hold_val", LW'(done_val), LW'(1'b1));
            check("done_hold_data", done_data, prev_dd);
         end
         if (done_val && !prev_dv) done_first_cyc = cyc;
         prev_dv = done_val;
         if (done_val && done_stall > 0) begin
            done_rdy = 0; done_stall--;
         end else begin
            done_rdy = ($urandom_range(99) < done_pct);
         end
         if (done_val && done_rdy) begin
            if (exp_done.size() == 0) fail_now("unexpected_done");
            else begin
               e = exp_done.pop_front();
               check("done_type", LW'(done_type), LW'(e.t));
               check("done_data", done_data, e.d);
               check("req_count", LW'(n_req), LW'(WORDS));
               check("resp_count", LW'(n_resp), LW'(WORDS));
            end
            n_req = 0; n_resp = 0;
            done_fire_cyc = cyc;
         end
         prev_dstall = done_val && !done_rdy;
         prev_dd = done_data;
      end
   end

   initial begin
      logic [LW-1:0] d;
      logic [31:0] a;
      int tmo;
      reset = 1; cmd_val = 0; cmd_type = 0; cmd_addr = '0; cmd_data = '0;
      memreq_rdy = 0; memresp_val = 0; memresp_type = 0; memresp_data = '0; done_rdy = 0;
      #12;
      check("rst_cmd_rdy", LW'(cmd_rdy), LW'(1'b1));
      check("rst_memreq_val", LW'(memreq_val), LW'(1'b0));
      check("rst_memresp_rdy", LW'(memresp_rdy), LW'(1'b0));
      check("rst_done_val", LW'(done_val), LW'(1'b0));
      check("rst_done_type", LW'(done_type), LW'(1'b0));
      check("rst_done_data", done_data, '0);
      @(posedge clk); #1; reset = 0;

      // Refill with 1-cycle memory: consecutive requests, done WORDS+2 after accept.
      issue(1'b0, 32'h1004, '0);
      wait_done();
      check("refill_latency", LW'(done_first_cyc - cmd_fire_cyc), LW'(WORDS + 2));

      issue(1'b1, 32'h2000, {32'hD, 32'hC, 32'hB, 32'hA});
      wait_done();

      // Throttled request side and slow memory, reading back the spilled line.
      alt_rdy = 1; dly_min = 3; dly_max = 3;
      issue(1'b0, 32'h2008, '0);
      wait_done();
      alt_rdy = 0; dly_min = 1; dly_max = 1;

      // Completion stalled; the next command waits with cmd_val held high.
      done_stall = 3;
      issue(1'b1, 32'h5010, {$urandom, $urandom, $urandom, $urandom});
      issue(1'b0, 32'h5014, '0);
      check("b2b_accept_after_done", LW'(cmd_fire_cyc), LW'(done_fire_cyc + 1));
      wait_done();

      // Reset mid-refill, then stale responses must be refused.
      issue(1'b0, 32'h6000, '0);
      tmo = 0;
      while (n_req < 2 && tmo < 50) begin @(posedge clk); #1; tmo++; end
      if (n_req < 2) fail_now("reset_setup");
      reset = 1;
      exp_req.delete(); exp_done.delete();
      #1;
      check("abort_memreq_val", LW'(memreq_val), LW'(1'b0));
      check("abort_memresp_rdy", LW'(memresp_rdy), LW'(1'b0));
      check("abort_cmd_rdy", LW'(cmd_rdy), LW'(1'b1));
      @(posedge clk); #1; reset = 0; stale_cnt = 3;
      repeat (4) begin @(posedge clk); #1; end
      issue(1'b1, 32'h3000, {32'h33, 32'h22, 32'h11, 32'h00});
      wait_done();
      issue(1'b0, 32'h300C, '0);
      wait_done();

      // Top of address space.
      issue(1'b0, 32'hFFFF_FFF8, '0);
      wait_done();

      rdy_pct = 70; resp_pct = 70; done_pct = 70; dly_min = 1; dly_max = 4;
      for (int k = 0; k < 40; k++) begin
         a = ($urandom_range(1) != 0) ? (32'h4000 + 32'($urandom_range(63))) : $urandom;
         d = {$urandom, $urandom, $urandom, $urandom};
         issue(1'($urandom), a, d);
         wait_done();
      end
      check("req_queue_drained", LW'(exp_req.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lab3_cache_line_xfer.md
Name: lab3_cache_line_xfer

Overview:
- Memory-side line transfer engine between the cache controller/datapath and main memory.
- Accepts one line command at a time: refill (read) or spill (write).
- Each command becomes WORDS single-word memory requests, with responses tracked in order.
- On completion, hands back the assembled refill line or a spill acknowledgement.
- Replaces per-word spill/refill counting in the cache controller with one line-level handshake.

Parameters:
- WORDS, 4, words per cache line (power of two, ≥2)
- DATA_W, 32, bits per word
- ADDR_W, 32, byte-address width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_val  in  1  line command valid
- cmd_rdy  out  1  engine can accept a command
- cmd_type  in  1  0 = refill (read), 1 = spill (write)
- cmd_addr  in  ADDR_W  line address; low offset bits ignored
- cmd_data  in  WORDS*DATA_W  spill line; word i at bits [i*DATA_W +: DATA_W]
- memreq_val  out  1  memory request valid
- memreq_rdy  in  1  memory ready
- memreq_type  out  1  0 = read, 1 = write
- memreq_addr  out  ADDR_W  word byte address
- memreq_data  out  DATA_W  write data (0 for reads)
- memresp_val  in  1  memory response valid
- memresp_rdy  out  1  engine accepts response
- memresp_type  in  1  response type, must equal the command type
- memresp_data  in  DATA_W  read data
- done_val  out  1  line transfer complete
- done_rdy  in  1  consumer accepts completion
- done_type  out  1  type of the completed command
- done_data  out  WORDS*DATA_W  refill line; 0 for spill

Behaviour:
- Reset: asynchronous and active-high; state, counters, line buffer and latched command are all cleared.
  - State goes to IDLE.
  - cmd_rdy=1; memreq_val=0; memresp_rdy=0; done_val=0; done_type=0; done_data=0.
  - Reset mid-transfer aborts the command. Responses to aborted requests are never accepted because memresp_rdy=0 in IDLE.
- Constants and counters:
  - OFF = log2(WORDS*DATA_W/8).
  - req_cnt and resp_cnt are each $clog2(WORDS)+1 bits wide.
- IDLE:
  - cmd_rdy=1.
  - On cmd_val&&cmd_rdy, latch:
    - type
    - base = cmd_addr with bits [OFF-1:0] cleared
    - cmd_data
  - Also zero req_cnt, resp_cnt and the line buffer, then go to XFER.
- XFER:
  - cmd_rdy=0.
  - memreq_val = (req_cnt < WORDS).
  - memreq_type = latched type.
  - memreq_addr = base + req_cnt*(DATA_W/8), modulo 2^ADDR_W.
  - memreq_data = spill word req_cnt for spill, 0 for refill.
  - req_cnt increments on memreq_val&&memreq_rdy.
  - memresp_rdy = (resp_cnt < req_cnt): only outstanding requests are accepted, so a response can never precede its request.
  - On memresp_val&&memresp_rdy:
    - Refill: write memresp_data into buffer word resp_cnt.
    - Spill: ignore the data.
    - Increment resp_cnt.
  - A request fire and a response fire in the same cycle are both counted.
  - Responses are assumed in order.
  - memresp_type mismatch is a simulation assertion error only; it has no RTL effect.
  - When the accepted response is the WORDS-th, go to DONE next cycle.
- DONE:
  - done_val=1; done_type = latched type.
  - done_data = line buffer for refill, 0 for spill.
  - cmd_rdy=0; memreq_val=0; memresp_rdy=0.
  - Outputs held stable while done_rdy=0.
  - On done_val&&done_rdy, go to IDLE. cmd_rdy rises the following cycle, so there is no same-cycle back-to-back accept.
- Latency:
  - Minimum from cmd fire to done_val, with 1-cycle memory and all ready signals high: WORDS+2 cycles.
  - Throughput: one request per cycle.
- memreq_* are combinational from registered state; no combinational path from memreq_rdy to memreq_val.
- Boundaries:
  - cmd_val during XFER/DONE: ignored, cmd_rdy=0.
  - memreq_rdy low: request held with stable addr/data until accepted.
  - Address wrap at top of space is modular.

Test Plan:
- Refill, cmd_addr=0x1004, memory responds 1 cycle after each request with data=addr -> reads issued to 0x1000, 0x1004, 0x1008, 0x100C in consecutive cycles; done_val after 6 cycles; done_data word i = 0x1000+4i; done_type=0.
- Spill, cmd_addr=0x2000, cmd_data words {0xA,0xB,0xC,0xD} -> writes (0x2000,0xA) … (0x200C,0xD); done_type=1; done_data=0.
- memreq_rdy alternating 0/1 and responses delayed 3 cycles -> each request held stable until accepted; exactly 4 requests and 4 responses; memresp_rdy never high with resp_cnt==req_cnt; done only after the 4th response.
- done_rdy low 3 cycles -> done_val and done_data stable; cmd_val high throughout is not accepted until the cycle after done fires.
- Assert reset after 2 of 4 refill requests -> next cycle in IDLE, memreq_val=0, memresp_rdy=0; stale responses ignored; new spill to 0x3000 completes correctly.
- Refill at cmd_addr=0xFFFFFFF8 -> addresses 0xFFFFFFF0…0xFFFFFFFC, with no wrap past the line.
